blowfish_round_ctrl: RTL and testbench

Sequencer that runs the 16-round Blowfish Feistel network around a shared F-function instance (`f_module`) and an external P-array read port. It accepts one 64-bit block per valid/ready handshake and reads P-subkeys one per round. It drives the F input, waits the configured F latency and applies the XOR/swap schedule. It presents the 64-bit result on a valid/ready output. It sits between the block I/O front end and the `f_module`/key-schedule storage.

---
 rtl/blowfish_round_ctrl.sv | 129 ++++++++++++
 tb/tb_blowfish_round_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/blowfish_round_ctrl.sv
// Blowfish 16-round Feistel sequencer around a shared F-function and external P-array port.
// Define BLOWFISH_DECRYPT_EN to enable the decrypt P-index map selected by `mode`.
module blowfish_round_ctrl #(
  parameter int unsigned F_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  output logic [31:0] f_in,
  input  logic [31:0] f_out,
  output logic        busy,
  output logic [3:0]  round
);

  typedef enum logic [2:0] {IDLE, RD, FW, FIN1, FIN2, DONE} state_t;

  state_t      state;
  logic [31:0] xl, xr;
  logic [3:0]  rnd, cnt;
  logic [4:0]  p_addr_q;

  logic [4:0]  addr_first, addr_next, addr_fin_r, addr_fin_l;

`ifdef BLOWFISH_DECRYPT_EN
  logic mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mode_q <= 1'b0;
    else if (state == IDLE && in_valid)
      mode_q <= mode;
  end

  // decrypt walks P backwards: round r uses P[17-r], so the next round is P[16-r]
  always_comb begin
    addr_first = mode ? 5'd17 : 5'd0;
    addr_next  = mode_q ? (5'd16 - {1'b0, rnd}) : ({1'b0, rnd} + 5'd1);
    addr_fin_r = mode_q ? 5'd1 : 5'd16;
    addr_fin_l = mode_q ? 5'd0 : 5'd17;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    addr_first = 5'd0;
    addr_next  = {1'b0, rnd} + 5'd1;
    addr_fin_r = 5'd16;
    addr_fin_l = 5'd17;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      xl       <= '0;
      xr       <= '0;
      rnd      <= '0;
      cnt      <= '0;
      p_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xl       <= in_data[63:32];
            xr       <= in_data[31:0];
            rnd      <= '0;
            p_addr_q <= addr_first;
            state    <= RD;
          end
        end
        RD: begin
          xl    <= xl ^ p_data;
          cnt   <= 4'(F_LAT - 1);
          state <= FW;
        end
        FW: begin
          if (cnt == '0) begin
            if (rnd != 4'd15) begin
              xl       <= xr ^ f_out;
              xr       <= xl;
              rnd      <= rnd + 4'd1;
              p_addr_q <= addr_next;
              state    <= RD;
            end else begin
              // last round leaves the halves unswapped
              xr       <= xr ^ f_out;
              p_addr_q <= addr_fin_r;
              state    <= FIN1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FIN1: begin
          xr       <= xr ^ p_data;
          p_addr_q <= addr_fin_l;
          state    <= FIN2;
        end
        FIN2: begin
          xl    <= xl ^ p_data;
          state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = {xl, xr};
  assign f_in      = xl;
  assign p_addr    = p_addr_q;
  assign round     = rnd;

endmodule

// File: tb/tb_blowfish_round_ctrl.sv
// Directed bench for blowfish_round_ctrl: stub P[i]=i, selectable stub F, three F_LAT variants.
// Expected blocks come from a reference Blowfish loop and are queued at accept, checked at output.
module tb_blowfish_round_ctrl;

`ifdef BLOWFISH_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  in_valid_v;
  logic [63:0] in_data;
  logic        mode, out_ready, fsel;

  logic        ir[3], ov[3], bz[3];
  logic [63:0] od[3];
  logic [4:0]  pa[3];
  logic [31:0] pd[3], fi[3], fo[3];
  logic [3:0]  rd[3];

  int unsigned sel;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_q[$];
  logic [4:0]  pseq[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] fstub(input logic [31:0] x, input logic en);
    return en ? ({x[28:0], x[31:29]} ^ 32'hDEADBEEF) : 32'h0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    assign pd[g] = {27'b0, pa[g]};
    assign fo[g] = fstub(fi[g], fsel);
    blowfish_round_ctrl #(.F_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[g]), .in_ready(ir[g]), .in_data(in_data), .mode(mode),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]),
      .p_addr(pa[g]), .p_data(pd[g]), .f_in(fi[g]), .f_out(fo[g]),
      .busy(bz[g]), .round(rd[g])
    );
  end

  logic        s_ir, s_ov, s_bz;
  logic [63:0] s_od;
  logic [4:0]  s_pa;
  logic [31:0] s_fi;
  logic [3:0]  s_rd;
  assign s_ir = ir[sel];
  assign s_ov = ov[sel];
  assign s_bz = bz[sel];
  assign s_od = od[sel];
  assign s_pa = pa[sel];
  assign s_fi = fi[sel];
  assign s_rd = rd[sel];

  function automatic logic [63:0] model(input logic [63:0] d, input logic dec, input logic fen);
    logic [31:0] l, r, t;
    l = d[63:32];
    r = d[31:0];
    for (int i = 0; i < 16; i++) begin
      l = l ^ 32'(dec ? 17 - i : i);
      r = r ^ fstub(l, fen);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ (dec ? 32'd1 : 32'd16);
    l = l ^ (dec ? 32'd0 : 32'd17);
    return {l, r};
  endfunction

  always @(negedge clk)
    if (!rst && s_bz && (pseq.size() == 0 || pseq[$] != s_pa))
      pseq.push_back(s_pa);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_in_ready"},  64'(s_ir), 64'd1);
    chk({pfx, "_out_valid"}, 64'(s_ov), 64'd0);
    chk({pfx, "_out_data"},  s_od, 64'd0);
    chk({pfx, "_p_addr"},    64'(s_pa), 64'd0);
    chk({pfx, "_f_in"},      64'(s_fi), 64'd0);
    chk({pfx, "_busy"},      64'(s_bz), 64'd0);
    chk({pfx, "_round"},     64'(s_rd), 64'd0);
  endtask

  task automatic run_block(input logic [63:0] d, input logic md, input logic [63:0] exp,
                           input int unsigned hold, input bit spam);
    int unsigned n, lat;
    logic eff;
    bit saw_ready;
    lat = (sel == 0) ? 2 : (sel == 1) ? 1 : 4;
    eff = md & DEC_EN;
    @(negedge clk);
    chk("in_ready_idle", 64'(s_ir), 64'd1);
    pseq.delete();
    in_valid_v[sel] = 1'b1;
    in_data   = d;
    mode      = md;
    out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    if (!spam) in_valid_v = '0;
    in_data = ~d;
    mode    = ~md;
    n = 0;
    saw_ready = 1'b0;
    while (!s_ov && n < 400) begin
      @(posedge clk); #1;
      n++;
      if (s_ir) saw_ready = 1'b1;
    end
    chk("latency", 64'(n), 64'(16 * (lat + 1) + 2));
    chk("in_ready_low_busy", 64'(saw_ready), 64'd0);
    in_valid_v = '0;
    for (int i = 0; i < int'(hold); i++) begin
      chk("stall_out_valid", 64'(s_ov), 64'd1);
      chk("stall_out_data", s_od, exp_q[0]);
      chk("stall_in_ready", 64'(s_ir), 64'd0);
      @(posedge clk); #1;
    end
    chk("out_data", s_od, exp_q.pop_front());
    chk("pseq_len", 64'(pseq.size()), 64'd18);
    for (int i = 0; i < pseq.size() && i < 18; i++)
      chk("p_addr_seq", 64'(pseq[i]), 64'(eff ? 17 - i : i));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_out_valid", 64'(s_ov), 64'd0);
    chk("post_in_ready", 64'(s_ir), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v, ct, vecs[2];
    int unsigned n;
    rst = 1'b1;
    in_valid_v = '0;
    in_data = '0;
    mode = 1'b0;
    out_ready = 1'b0;
    fsel = 1'b0;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;

    // stub F = 0, F_LAT = 2
    v = 64'h89ABCDEF_01234567;
    run_block(v, 1'b0, model(v, 1'b0, 1'b0), 0, 1'b0);
    run_block(v, 1'b1, model(v, DEC_EN, 1'b0), 0, 1'b0);
    run_block(64'hCAFEF00D_12345678, 1'b0, model(64'hCAFEF00D_12345678, 1'b0, 1'b0), 10, 1'b1);
    run_block(64'h0F0F0F0F_F0F0F0F0, 1'b0, model(64'h0F0F0F0F_F0F0F0F0, 1'b0, 1'b0), 0, 1'b0);

    // async reset in the middle of round 7
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    in_data = 64'hA5A5A5A5_5A5A5A5A;
    mode = 1'b0;
    @(posedge clk); #1;
    in_valid_v = '0;
    exp_q.push_back(model(64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b0));
    n = 0;
    while (s_rd != 4'd7 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_round7", 64'(s_rd), 64'd7);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    void'(exp_q.pop_back());
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_block(v, 1'b0, model(v, 1'b0, 1'b0), 0, 1'b0);

    // nontrivial F, F_LAT = 1 and 4
    fsel = 1'b1;
    vecs[0] = 64'h00000000_FFFFFFFF;
    vecs[1] = 64'h01234567_89ABCDEF;
    for (int s = 1; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 2; k++) begin
        ct = model(vecs[k], 1'b0, 1'b1);
        run_block(vecs[k], 1'b0, ct, 0, 1'b0);
`ifdef BLOWFISH_DECRYPT_EN
        run_block(ct, 1'b1, vecs[k], 0, 1'b0);
`else
        run_block(vecs[k], 1'b1, ct, 0, 1'b0);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
